// File: rtl/hold_decoder_pkg.sv
// rtl/hold_decoder_pkg.sv - shared state type and width helper for the hold decoder
package hold_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HELD  = 2'd2
  } state_t;

  // Bits needed to hold n distinct values (0 .. n-1), never less than 1.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hold_decoder_if.sv
// rtl/hold_decoder_if.sv - pulse input and decoded event outputs of the hold decoder
interface hold_decoder_if #(
  parameter int CNT_W = 8
);

  logic             in;
  logic             held;
  logic             press;
  logic             release_evt;
  logic             err;
  logic [CNT_W-1:0] count;

  modport master (
    output in,
    input  held, press, release_evt, err, count
  );

  modport slave (
    input  in,
    output held, press, release_evt, err, count
  );

endinterface

// File: rtl/hold_decoder_gap_timer.sv
// rtl/hold_decoder_gap_timer.sv - gap counter since the last pulse with window/early/timeout flags
module gap_timer
  import hold_decoder_pkg::*;
#(
  parameter int LONG  = 5,
  parameter int SLACK = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic in_window,
  output logic early,
  output logic timeout
);

  localparam int             G_W    = width_for(LONG + SLACK + 1);
  localparam logic [G_W-1:0] G_MAX  = G_W'(LONG + SLACK);
  localparam logic [G_W-1:0] G_LONG = G_W'(LONG);

  logic [G_W-1:0] g;

  // Reset parks g at its ceiling so the first pulse never looks early.
  always_ff @(posedge clk) begin
    if (rst) begin
      g <= G_MAX;
    end else if (in) begin
      g <= '0;
    end else if (g != G_MAX) begin
      g <= g + 1'b1;
    end
  end

  assign early     = in && (g < G_LONG);
  assign in_window = in && (g >= G_LONG);
  assign timeout   = !in && (g == G_MAX);

endmodule

// File: rtl/hold_decoder.sv
// rtl/hold_decoder.sv - decodes a periodic pulse train into press/hold/release events
module hold_decoder
  import hold_decoder_pkg::*;
#(
  parameter int LONG        = 5,
  parameter int SLACK       = 1,
  parameter int MIN_REPEATS = 2,
  parameter int CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst,
  hold_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] count_q, count_n, count_inc;
  logic             press_q, press_n;
  logic             rel_q, rel_n;
  logic             err_q, err_n;
  logic             in_window, early, timeout;

  gap_timer #(
    .LONG  (LONG),
    .SLACK (SLACK)
  ) u_gap_timer (
    .clk       (clk),
    .rst       (rst),
    .in        (bus.in),
    .in_window (in_window),
    .early     (early),
    .timeout   (timeout)
  );

  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      press_q <= press_n;
      rel_q   <= rel_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    press_n = 1'b0;
    rel_n   = 1'b0;
    err_n   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in) begin
          state_n = ARMED;
          count_n = CNT_W'(1);
          press_n = 1'b1;
        end
      end
      ARMED: begin
        if (early) begin
          err_n   = 1'b1;
          count_n = CNT_W'(1);
        end else if (in_window) begin
          count_n = count_inc;
          if (int'(count_inc) >= MIN_REPEATS) state_n = HELD;
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      HELD: begin
        if (early) begin
          err_n   = 1'b1;
          rel_n   = 1'b1;
          count_n = CNT_W'(1);
          state_n = ARMED;
        end else if (in_window) begin
          count_n = count_inc;
        end else if (timeout) begin
          rel_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.held        = (state_q == HELD);
  assign bus.press       = press_q;
  assign bus.release_evt = rel_q;
  assign bus.err         = err_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_hold_decoder.sv
// tb/tb_hold_decoder.sv - randomized self-checking bench for hold_decoder
module tb_hold_decoder;

  localparam int LONG        = 5;
  localparam int SLACK       = 1;
  localparam int MIN_REPEATS = 2;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hold_decoder_if #(.CNT_W(CNT_W)) bus ();

  hold_decoder #(
    .LONG        (LONG),
    .SLACK       (SLACK),
    .MIN_REPEATS (MIN_REPEATS),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference: mode 0 idle, 1 armed, 2 held; since = pulse-free cycles since last pulse.
  int m_mode  = 0;
  int m_count = 0;
  int since   = LONG + SLACK;
  bit e_press, e_rel, e_err;
  int saw_err_in_slack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit v, input bit r);
    @(negedge clk);
    bus.in = v;
    rst    = r;
    e_press = 0; e_rel = 0; e_err = 0;
    if (r) begin
      m_mode = 0; m_count = 0; since = LONG + SLACK;
    end else begin
      if (v) begin
        if (m_mode == 0) begin
          m_mode = 1; m_count = 1; e_press = 1;
        end else if (since < LONG) begin
          e_err = 1;
          if (m_mode == 2) e_rel = 1;
          m_mode = 1; m_count = 1;
        end else begin
          m_count = (m_count >= CNT_MAX) ? CNT_MAX : m_count + 1;
          if (m_mode == 1 && m_count >= MIN_REPEATS) m_mode = 2;
        end
      end else if (m_mode != 0 && since >= LONG + SLACK) begin
        if (m_mode == 2) e_rel = 1;
        m_mode = 0;
      end
      since = v ? 0 : since + 1;
    end
    @(posedge clk);
    #1;
    check("held",    32'(bus.held),        32'(m_mode == 2));
    check("press",   32'(bus.press),       32'(e_press));
    check("release", 32'(bus.release_evt), 32'(e_rel));
    check("err",     32'(bus.err),         32'(e_err));
    check("count",   32'(bus.count),       32'(m_count));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic train(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0);
      idle(period - 1);
    end
  endtask

  initial begin
    bus.in = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_held",  32'(bus.held),  32'd0);

    // single pulse then idle
    idle(3);
    step(1'b1, 1'b0);
    check("single_press", 32'(bus.press), 32'd1);
    idle(8);
    check("single_count", 32'(bus.count), 32'd1);

    // nominal train, then timeout release
    train(4, LONG + 1);
    check("train_held",  32'(bus.held),  32'd1);
    check("train_count", 32'(bus.count), 32'd4);
    idle(10);

    // slack slot accepted without err
    step(1'b1, 1'b0); idle(LONG + SLACK);
    step(1'b1, 1'b0);
    check("slack_held", 32'(bus.held), 32'd1);
    idle(LONG + SLACK);
    step(1'b1, 1'b0);
    check("slack_noerr", 32'(bus.err), 32'd0);

    // early pulse from HELD: err+release together
    idle(2);
    step(1'b1, 1'b0);
    check("early_err", 32'(bus.err), 32'd1);
    check("early_rel", 32'(bus.release_evt), 32'd1);
    check("early_cnt", 32'(bus.count), 32'd1);
    idle(LONG);
    step(1'b1, 1'b0);
    check("reenter_held", 32'(bus.held), 32'd1);

    // continuous level: one err per cycle
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    idle(12);

    // saturation
    train(300, LONG + 1);
    check("sat_count", 32'(bus.count), 32'(CNT_MAX));
    check("sat_held",  32'(bus.held),  32'd1);

    // reset mid-hold, then press
    step(1'b0, 1'b1);
    check("rst_rel", 32'(bus.release_evt), 32'd0);
    step(1'b1, 1'b0);
    check("rst_press", 32'(bus.press), 32'd1);
    idle(10);

    // randomized: gaps around the window edges, bursts, rare resets
    for (int k = 0; k < 400; k++) begin
      int gap;
      gap = $urandom_range(0, LONG + SLACK + 3);
      step(1'b1, ($urandom_range(0, 60) == 0));
      idle(gap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hold_decoder.md
HOLD_DECODER -- requirements
Module: hold_decoder

Interface
REQ-001 The block SHALL have parameter LONG, default 5: nominal repeat gap; an in-spec pulse train has one pulse every LONG+1 cycles.
REQ-002 The block SHALL have parameter SLACK, default 1: extra cycles tolerated after the nominal slot before timeout.
REQ-003 The block SHALL have parameter MIN_REPEATS, default 2, legal range >= 2: count of in-window pulses, including the first pulse, needed to declare hold.
REQ-004 The block SHALL have parameter CNT_W, default 8: width of the pulse counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port in, input, 1 bit: pulse stream; every cycle with in=1 is one pulse.
REQ-008 The block SHALL have port held, output, 1 bit: high while a valid repeat stream is decoded.
REQ-009 The block SHALL have port press, output, 1 bit: one-cycle pulse on the first pulse from IDLE.
REQ-010 The block SHALL have port release, output, 1 bit: one-cycle pulse when held drops.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse on an early pulse.
REQ-012 The block SHALL have port count, output, CNT_W bits: pulses accepted in the current stream, saturating at all-ones.

Function
REQ-013 The gap counter g SHALL load 0 on the cycle after any pulse and increment each pulse-free cycle, saturating at LONG+SLACK; g is g_w = clog2(LONG+SLACK+1) bits wide.
REQ-014 A pulse SHALL be classified "in window" when LONG <= g <= LONG+SLACK and "early" when g < LONG.
REQ-015 Timeout SHALL occur when g == LONG+SLACK, in=0, and the state is not IDLE.
REQ-016 The FSM SHALL have states IDLE, ARMED and HELD.
REQ-017 In IDLE, a pulse SHALL move the FSM to ARMED, load count=1 and pulse press.
REQ-018 In ARMED, an in-window pulse SHALL increment count; if the new count >= MIN_REPEATS, the FSM SHALL move to HELD.
REQ-019 In ARMED, an early pulse SHALL pulse err, reload count=1 and keep the FSM in ARMED.
REQ-020 In ARMED, timeout SHALL return the FSM to IDLE with no release.
REQ-021 In HELD, an in-window pulse SHALL increment count with saturation.
REQ-022 In HELD, an early pulse SHALL pulse err and release, reload count=1 and move the FSM to ARMED.
REQ-023 In HELD, timeout SHALL pulse release and move the FSM to IDLE.
REQ-024 count SHALL retain its last value in IDLE until the next press reloads 1.
REQ-025 All outputs SHALL be registered; press, release and err SHALL assert on the cycle after the triggering clock edge's inputs; held SHALL equal (state==HELD).
REQ-026 press, release and err SHALL each be exactly one cycle wide; release and err may coincide, and press never coincides with either.
REQ-027 A continuous level in=1 from ARMED or HELD SHALL be treated as back-to-back early pulses, producing one err per cycle.
REQ-028 A pulse arriving exactly on the timeout cycle SHALL be treated as in window; timeout SHALL not occur on that cycle.
REQ-029 Incrementing count at all-ones SHALL hold the value at all-ones.

Reset
REQ-030 While rst=1 at a clock edge: state SHALL go to IDLE, g SHALL go to LONG+SLACK, count SHALL go to 0, and held, press, release and err SHALL go to 0.
REQ-031 rst SHALL override in on the same cycle.
REQ-032 Reset asserted mid-stream SHALL produce no release pulse.
REQ-033 The first pulse after reset SHALL be handled as from IDLE.

Structure
REQ-034 A shared package SHALL hold the state enum {IDLE, ARMED, HELD} and a width helper used for g_w.
REQ-035 The gap counter and its window/early/timeout classification SHALL be a sub-module named gap_timer, with parameters LONG and SLACK, inputs clk, rst and in, and outputs in_window, early and timeout.
REQ-036 The FSM, count and output registers SHALL reside in hold_decoder.

Verification (LONG=5, SLACK=1, MIN_REPEATS=2, CNT_W=8)
REQ-037 Scenario: single pulse at cycle 10, then idle -> press=1 at cycle 11, count=1, held never 1, no release, and the FSM is in IDLE by cycle 18.
REQ-038 Scenario: pulses at cycles 10, 16, 22, 28, then stop -> held=1 from cycle 17, count=4, then release is one cycle wide and held falls when timeout fires 7 cycles after the last pulse.
REQ-039 Scenario: pulses at cycles 10 and 17 (slack slot), then 24 -> all accepted, held rises at 18, and there is no err.
REQ-040 Scenario: held stream at period 6, then a pulse only 3 cycles after the previous one -> err and release in the same cycle, count=1, FSM in ARMED, and the next pulse 6 cycles later re-enters HELD.
REQ-041 Scenario: 300 in-window pulses -> count saturates at 255 and held stays 1.
REQ-042 Scenario: rst asserted while in HELD -> the next cycle has held=0, count=0 and no release; a following pulse produces press.
